dac_fifo_ctrl: RTL
==================

Name: dac_fifo_ctrl

Overview:
Controller for the DAC sample FIFO. It owns both FIFO ports:
- Accepts samples from an upstream producer via a valid/ready handshake and drives the FIFO write port.
- Tracks FIFO occupancy; the FIFO exports no flags.
- Pops samples at a programmable sample rate and presents each one to the DAC with a one-cycle strobe.
- Handles prefill before playout and detects underrun.

Parameters:
BITS, 4, sample width; must match the FIFO instance.
SIZE, 4, FIFO depth in entries; must match the FIFO instance.
PREFILL, 2, level required before playout starts; legal range 1..SIZE.
DIV_WIDTH, 16, width of the rate divider.
LW, $clog2(SIZE+1), width of the level counter (localparam).

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset, asynchronous, active-low.
enable  in  1  playout enable.
rate_div  in  DIV_WIDTH  sample period minus 1, in clk cycles.
s_valid  in  1  upstream sample valid.
s_data  in  BITS  upstream sample.
s_ready  out  1  controller can accept a sample.
fifo_wr_en  out  1  FIFO write strobe.
fifo_wr_data  out  BITS  FIFO write data.
fifo_rd_en  out  1  FIFO read strobe.
fifo_rd_data  in  BITS  FIFO read data, valid the cycle after fifo_rd_en.
dac_data  out  BITS  current DAC sample (registered).
dac_strobe  out  1  one-cycle pulse when dac_data updates.
level  out  LW  current FIFO occupancy.
underrun  out  1  sticky underrun flag.
clr_underrun  in  1  clears underrun.
running  out  1  high while in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, level=0, tick counter=0, rd_pending=0.
  - All outputs 0: dac_data, dac_strobe, fifo_rd_en, underrun.
  - The FIFO pointers must be in their initial state whenever rst_n deasserts. A mid-operation reset therefore also requires a FIFO reinitialisation; the controller does not drain.
- Write side:
  - s_ready = (level != SIZE), decoded from the level register, with no combinational path from s_valid.
  - A push is accepted when s_valid & s_ready. On the same cycle: fifo_wr_en=1 and fifo_wr_data=s_data, both combinational pass-through.
  - A push is never accepted at level==SIZE, even if a pop occurs in the same cycle.
- Level:
  - push only: +1. pop only: -1. push and pop together: unchanged.
  - Level never exceeds SIZE and never goes below 0.
- Tick counter:
  - Runs only in RUN. It counts 0..rate_div; tick=1 on the cycle count==rate_div, then the counter returns to 0.
  - The sample period is rate_div+1 cycles; rate_div=0 gives a tick every cycle.
  - The counter is cleared on entry to RUN.
  - A rate_div change takes effect at the next compare. If count>rate_div, the counter wraps through its maximum value; this is legal, not an error.
- State machine:
  - IDLE: no pops. If enable is high, go to PREFILL.
  - PREFILL: no pops. If enable is low, go to IDLE. If level >= PREFILL, go to RUN.
  - RUN, enable low: go to IDLE immediately. Any rd_pending capture still completes.
  - RUN, tick with level>0: fifo_rd_en=1 for exactly one cycle and rd_pending<=1. Next cycle: dac_data<=fifo_rd_data, dac_strobe=1.
  - RUN, tick with level==0: underrun<=1, no pop, dac_data holds its last value, go to PREFILL.
  - Playout resumes only after the prefill condition is met again.
- FIFO contents and level are retained across IDLE and PREFILL.
- fifo_rd_en is only ever asserted when level>0, so there is no pop on empty.
- underrun: set has priority over clr_underrun on the same cycle.
- running = (state==RUN).
- dac_strobe is always a single-cycle pulse, at most one per tick.

Decomposition:
- Shared package dac_pkg holds:
  - the state encoding: IDLE=2'd0, PREFILL=2'd1, RUN=2'd2;
  - the LW computation helper.
- Natural sub-module: dac_rate_tick, containing the divider counter, its clear and tick output.
- The FIFO is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use BITS=4, SIZE=4, PREFILL=2.
1. Reset, enable=1, rate_div=3, push D,E: after the second push, state goes to RUN. The first fifo_rd_en comes 4 cycles after RUN entry. dac_data=D with dac_strobe one cycle after that pop; dac_data=E exactly 4 cycles later.
2. Push D,E,A,4 with enable=0: level=4, s_ready=0. A fifth s_valid produces no fifo_wr_en and level stays 4. A push on the same cycle as a pop (enable=1) is also refused.
3. Steady RUN with level=1 and push+pop on the same cycle: level stays 1 and the data order is preserved on dac_data.
4. RUN, allow the FIFO to drain: the next tick sets underrun=1, fifo_rd_en stays 0, dac_data holds its last value, and the state goes to PREFILL. Two pushes return the state to RUN. clr_underrun clears the flag. clr_underrun asserted on the same cycle as a new underrun leaves underrun=1.
5. rate_div=0 with level=4: four consecutive dac_strobe pulses, one per cycle, carrying D,E,A,4 in order, then underrun.
6. Mid-RUN enable=0 on a tick cycle: that pop still completes with one dac_strobe, then the state is IDLE and there are no further pops. rst_n asserted asynchronously mid-RUN clears all outputs within the same cycle.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC FIFO controller: state encoding and
// level-counter width.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Level must represent 0..size inclusive.
  function automatic int level_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/dac_fifo_ctrl_if.sv
// Sample handshake, FIFO port and DAC output bundle of the DAC FIFO controller.
// slave = controller side, master = producer/FIFO/DAC side.
interface dac_fifo_ctrl_if #(
  parameter int BITS = 4
);
  logic            s_valid;
  logic [BITS-1:0] s_data;
  logic            s_ready;
  logic            fifo_wr_en;
  logic [BITS-1:0] fifo_wr_data;
  logic            fifo_rd_en;
  logic [BITS-1:0] fifo_rd_data;
  logic [BITS-1:0] dac_data;
  logic            dac_strobe;

  modport slave (
    input  s_valid, s_data, fifo_rd_data,
    output s_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, dac_data, dac_strobe
  );

  modport master (
    output s_valid, s_data, fifo_rd_data,
    input  s_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, dac_data, dac_strobe
  );
endinterface

// File: rtl/dac_rate_tick.sv
// Sample-rate divider: counts 0..rate_div while run is high and pulses tick
// on the terminal count. Held at zero while not running.
module dac_rate_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] rate_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // A count above a newly lowered rate_div simply wraps through the maximum.
  always_comb begin
    tick  = run && (cnt_q == rate_div);
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (!run || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_fifo_ctrl.sv
// DAC sample FIFO controller: accepts upstream samples, tracks FIFO level,
// prefills, then pops one sample per rate tick into a registered DAC output.
module dac_fifo_ctrl
  import dac_pkg::*;
#(
  parameter  int BITS      = 4,
  parameter  int SIZE      = 4,
  parameter  int PREFILL   = 2,
  parameter  int DIV_WIDTH = 16,
  localparam int LW        = level_width(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] rate_div,
  input  logic                 clr_underrun,
  dac_fifo_ctrl_if.slave       bus,
  output logic [LW-1:0]        level,
  output logic                 underrun,
  output logic                 running
);

  localparam logic [LW-1:0] LVL_FULL    = LW'(SIZE);
  localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic            rd_pending_q, rd_pending_d;
  logic [BITS-1:0] dac_data_q, dac_data_d;
  logic            dac_strobe_q, dac_strobe_d;
  logic            underrun_q, underrun_d;

  logic tick, in_run, push, pop, starved;

  dac_rate_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (in_run),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // s_ready comes from the level register only, so a pop never frees a slot
  // in the same cycle and there is no path from s_valid back to s_ready.
  assign in_run  = (state_q == ST_RUN);
  assign push    = bus.s_valid && (level_q != LVL_FULL);
  assign pop     = in_run && tick && (level_q != '0);
  assign starved = in_run && tick && (level_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      rd_pending_q <= 1'b0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      rd_pending_q <= rd_pending_d;
      dac_data_q   <= dac_data_d;
      dac_strobe_q <= dac_strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (!enable)                     state_d = ST_IDLE;
        else if (level_q >= LVL_PREFILL) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)     state_d = ST_IDLE;
        else if (starved) state_d = ST_PREFILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop issued on the cycle enable drops still lands via rd_pending.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    rd_pending_d = pop;
    dac_strobe_d = rd_pending_q;
    dac_data_d   = rd_pending_q ? bus.fifo_rd_data : dac_data_q;

    underrun_d = underrun_q;
    if (starved)           underrun_d = 1'b1;
    else if (clr_underrun) underrun_d = 1'b0;
  end

  assign bus.s_ready      = (level_q != LVL_FULL);
  assign bus.fifo_wr_en   = push;
  assign bus.fifo_wr_data = bus.s_data;
  assign bus.fifo_rd_en   = pop;
  assign bus.dac_data     = dac_data_q;
  assign bus.dac_strobe   = dac_strobe_q;
  assign level            = level_q;
  assign underrun         = underrun_q;
  assign running          = in_run;

endmodule
